pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Parametrised successor to the single-cycle program-counter unit.
- Holds the architectural PC and computes the next PC for sequential flow, all six RV32I conditional branches, JAL and JALR.
- Adds a fetch stall, misaligned-target trapping with registered trap reporting, and a taken-redirect counter.
- Sits between decode/ALU flag outputs and the instruction-memory address port.

Parameters:
- XLEN, 32, width of the PC, immediates and operands.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a misaligned redirect is detected.
- IALIGN, 4, instruction alignment in bytes. Legal values are 2 or 4. Also the sequential increment.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC. No state updates while asserted.
- branch  in  1  current instruction is a conditional branch.
- branch_op  in  3  funct3 of the branch.
- zero_flag  in  1  ALU result equals zero (rs1==rs2).
- lt_flag  in  1  signed rs1<rs2.
- ltu_flag  in  1  unsigned rs1<rs2.
- jal  in  1  current instruction is JAL.
- jalr  in  1  current instruction is JALR.
- imm  in  XLEN  sign-extended byte offset. Not pre-shifted.
- rs1_val  in  XLEN  rs1 operand for JALR.
- pc_out  out  XLEN  current PC, to instruction memory.
- link_out  out  XLEN  pc_out+IALIGN. Return address for JAL/JALR.
- taken  out  1  combinational: a redirect is selected this cycle.
- trap_valid  out  1  registered one-cycle pulse: a misaligned redirect was trapped.
- trap_epc  out  XLEN  PC of the trapping instruction. Held until the next trap.
- trap_tval  out  XLEN  offending target address. Held until the next trap.
- redirect_count  out  CNT_W  count of successful taken redirects.

Behaviour:
- Reset (async, immediate):
  - pc_out=RESET_VECTOR.
  - trap_valid=0, trap_epc=0, trap_tval=0, redirect_count=0.
  - Reset asserted mid-stall or mid-trap overrides everything.
- Arithmetic: all sums are modulo 2^XLEN and wrap silently.
  - seq = pc+IALIGN.
  - br_tgt = pc+imm. This is used for JAL and branches.
  - jalr_tgt = (rs1_val+imm) with bit0 cleared.
- Branch condition by branch_op:
  - 000 BEQ: zero_flag.
  - 001 BNE: !zero_flag.
  - 100 BLT: lt_flag.
  - 101 BGE: !lt_flag.
  - 110 BLTU: ltu_flag.
  - 111 BGEU: !ltu_flag.
  - 010/011: never taken.
  - cond is qualified by branch.
- Selection priority: jalr > jal > (branch&&cond) > seq.
  - jal and jalr asserted together: jalr wins.
  - taken=1 for any non-seq selection.
- Misalignment check:
  - IALIGN=4: selected redirect target has bit1 or bit0 set (bit1 only for JALR).
  - IALIGN=2: bit0 set (never true for JALR).
  - Checked only when taken=1. A not-taken branch with a misaligned br_tgt does not trap.
- Rising edge with stall=1:
  - pc_out, trap registers and redirect_count hold.
  - trap_valid is driven 0.
  - Combinational outputs still track inputs.
- Rising edge with stall=0:
  - Misaligned taken:
    - pc_out<=TRAP_VECTOR.
    - trap_valid<=1 for exactly one cycle.
    - trap_epc<=old pc.
    - trap_tval<=offending target.
    - redirect_count unchanged.
  - Aligned taken: pc_out<=target, redirect_count<=redirect_count+1 (wraps at 2^CNT_W), trap_valid<=0.
  - Otherwise: pc_out<=seq, trap_valid<=0.
- Latency: next PC is visible one cycle after the decision. trap_valid is visible in the same cycle pc_out becomes TRAP_VECTOR.
- Back-to-back traps: each produces its own pulse and overwrites epc/tval.

Test Plan:
- Reset released, 3 unstalled cycles, no control inputs -> pc_out 0,4,8,12; redirect_count=0; link_out=16 at pc 12.
- pc=0x20, branch=1, op=000, zero=1, imm=-8 -> pc_out=0x18, taken=1, count=1. Repeat with op=001 -> pc_out=0x1C, count unchanged.
- pc=0x40, jalr=1, jal=1, rs1=0x1001, imm=2 -> pc_out=0x1002 when IALIGN=2. When IALIGN=4 -> pc_out=0x100, trap_valid pulse, epc=0x40, tval=0x1002.
- stall=1 for 3 cycles while jal with imm=0x10 is asserted -> pc_out, count and trap unchanged. Release -> single redirect to pc+0x10, count+1.
- pc=0xFFFF_FFFC unstalled -> pc_out=0x0 (wrap). redirect_count preloaded to 0xFFFF then one taken jal -> 0x0000.
- Assert reset asynchronously mid-cycle during a trap pulse -> pc_out=RESET_VECTOR and trap_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter with branch/jump redirect, misalignment trap and redirect counter
module pc_next_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int              IALIGN       = 4,
   parameter int              CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch,
   input  logic [2:0]       branch_op,
   input  logic             zero_flag,
   input  logic             lt_flag,
   input  logic             ltu_flag,
   input  logic             jal,
   input  logic             jalr,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1_val,
   output logic [XLEN-1:0]  pc_out,
   output logic [XLEN-1:0]  link_out,
   output logic             taken,
   output logic             trap_valid,
   output logic [XLEN-1:0]  trap_epc,
   output logic [XLEN-1:0]  trap_tval,
   output logic [CNT_W-1:0] redirect_count
);

   logic [XLEN-1:0] seq;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_tgt;
   logic [XLEN-1:0] target;
   logic            cond;
   logic            misaligned;

   always_comb begin
      seq      = pc_out + XLEN'(IALIGN);
      br_tgt   = pc_out + imm;
      jalr_sum = rs1_val + imm;
      jalr_tgt = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};

      case (branch_op)
         3'b000:  cond = zero_flag;
         3'b001:  cond = !zero_flag;
         3'b100:  cond = lt_flag;
         3'b101:  cond = !lt_flag;
         3'b110:  cond = ltu_flag;
         3'b111:  cond = !ltu_flag;
         default: cond = 1'b0;
      endcase

      target = seq;
      taken  = 1'b0;
      if (jalr) begin
         target = jalr_tgt;
         taken  = 1'b1;
      end else if (jal) begin
         target = br_tgt;
         taken  = 1'b1;
      end else if (branch && cond) begin
         target = br_tgt;
         taken  = 1'b1;
      end

      // JALR has bit0 cleared already, so the same test covers all redirect kinds
      misaligned = taken && ((IALIGN == 4) ? (target[1] | target[0]) : target[0]);
      link_out   = seq;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_out         <= RESET_VECTOR;
         trap_valid     <= 1'b0;
         trap_epc       <= '0;
         trap_tval      <= '0;
         redirect_count <= '0;
      end else if (stall) begin
         trap_valid <= 1'b0;
      end else if (misaligned) begin
         pc_out     <= TRAP_VECTOR;
         trap_valid <= 1'b1;
         trap_epc   <= pc_out;
         trap_tval  <= target;
      end else begin
         pc_out     <= target;
         trap_valid <= 1'b0;
         if (taken)
            redirect_count <= redirect_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - randomized and directed check of pc_next_unit against a behavioural model
module tb_pc_next_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branch, zero_flag, lt_flag, ltu_flag, jal, jalr;
   logic [2:0]  branch_op;
   logic [31:0] imm, rs1_val;

   logic [31:0] pc_a, link_a, epc_a, tval_a, pc_b, link_b, epc_b, tval_b;
   logic        taken_a, tv_a, taken_b, tv_b;
   logic [15:0] cnt_a, cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: index 0 is IALIGN=4, index 1 is IALIGN=2
   logic [31:0] m_pc[2], m_epc[2], m_tval[2];
   logic        m_tv[2];
   logic [15:0] m_cnt[2];
   int          ia[2] = '{4, 2};

   always #5 clk = ~clk;

   pc_next_unit u_a (
      .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_op(branch_op),
      .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .jal(jal), .jalr(jalr),
      .imm(imm), .rs1_val(rs1_val), .pc_out(pc_a), .link_out(link_a), .taken(taken_a),
      .trap_valid(tv_a), .trap_epc(epc_a), .trap_tval(tval_a), .redirect_count(cnt_a)
   );

   pc_next_unit #(.IALIGN(2)) u_b (
      .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_op(branch_op),
      .zero_flag(zero_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag), .jal(jal), .jalr(jalr),
      .imm(imm), .rs1_val(rs1_val), .pc_out(pc_b), .link_out(link_b), .taken(taken_b),
      .trap_valid(tv_b), .trap_epc(epc_b), .trap_tval(tval_b), .redirect_count(cnt_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_holds();
      case (branch_op)
         3'd0: return zero_flag;
         3'd1: return !zero_flag;
         3'd4: return lt_flag;
         3'd5: return !lt_flag;
         3'd6: return ltu_flag;
         3'd7: return !ltu_flag;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_target(input int k, output bit tk, output logic [31:0] tgt);
      tk = 1'b1;
      if (jalr)                          tgt = (rs1_val + imm) & ~32'd1;
      else if (jal)                      tgt = m_pc[k] + imm;
      else if (branch && cond_holds())   tgt = m_pc[k] + imm;
      else begin
         tk  = 1'b0;
         tgt = m_pc[k] + 32'(ia[k]);
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_tval[k] = 32'h0; m_tv[k] = 1'b0; m_cnt[k] = 16'h0;
      end
   endtask

   task automatic check_regs();
      chk("pc_a", pc_a, m_pc[0]);          chk("pc_b", pc_b, m_pc[1]);
      chk("trap_valid_a", {31'd0, tv_a}, {31'd0, m_tv[0]});
      chk("trap_valid_b", {31'd0, tv_b}, {31'd0, m_tv[1]});
      chk("epc_a", epc_a, m_epc[0]);       chk("epc_b", epc_b, m_epc[1]);
      chk("tval_a", tval_a, m_tval[0]);    chk("tval_b", tval_b, m_tval[1]);
      chk("count_a", {16'd0, cnt_a}, {16'd0, m_cnt[0]});
      chk("count_b", {16'd0, cnt_b}, {16'd0, m_cnt[1]});
   endtask

   // inputs are set at a falling edge; checks combinational outputs, clocks once, checks registers
   task automatic step();
      bit          tk[2];
      logic [31:0] tgt[2];
      #1;
      for (int k = 0; k < 2; k++) model_target(k, tk[k], tgt[k]);
      chk("taken_a", {31'd0, taken_a}, {31'd0, tk[0]});
      chk("taken_b", {31'd0, taken_b}, {31'd0, tk[1]});
      chk("link_a", link_a, m_pc[0] + 32'd4);
      chk("link_b", link_b, m_pc[1] + 32'd2);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (stall) begin
            m_tv[k] = 1'b0;
         end else if (tk[k] && (tgt[k] % 32'(ia[k])) != 0) begin
            m_epc[k] = m_pc[k]; m_tval[k] = tgt[k]; m_pc[k] = 32'h100; m_tv[k] = 1'b1;
         end else begin
            m_pc[k] = tgt[k]; m_tv[k] = 1'b0;
            if (tk[k]) m_cnt[k] = m_cnt[k] + 16'd1;
         end
      end
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic set_in(input logic b, input logic [2:0] op, input logic z, input logic j,
                         input logic jr, input logic [31:0] im, input logic [31:0] r1);
      stall = 1'b0; branch = b; branch_op = op; zero_flag = z; lt_flag = 1'b0; ltu_flag = 1'b0;
      jal = j; jalr = jr; imm = im; rs1_val = r1;
   endtask

   task automatic idle();
      set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   logic [15:0] cnt_before;

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_regs();
      chk("reset_pc", pc_a, 32'h0);

      idle(); step(); chk("seq_4", pc_a, 32'h4);
      step();         chk("seq_8", pc_a, 32'h8);
      step();         chk("seq_12", pc_a, 32'hC);
      #1 chk("link_16", link_a, 32'h10);
      chk("count_zero", {16'd0, cnt_a}, 32'h0);

      set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h14, 32'h0); step();
      chk("jal_to_20", pc_a, 32'h20);
      cnt_before = cnt_a;
      set_in(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
      #1 chk("beq_taken", {31'd0, taken_a}, 32'h1);
      step();
      chk("beq_pc", pc_a, 32'h18);
      chk("beq_count", {16'd0, cnt_a}, {16'd0, cnt_before + 16'd1});
      set_in(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0); step();
      chk("bne_pc", pc_a, 32'h1C);
      chk("bne_count", {16'd0, cnt_a}, {16'd0, cnt_before + 16'd1});

      set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0); step();
      chk("jal_to_40", pc_a, 32'h40);
      set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'h2, 32'h1001); step();
      chk("jalr_trap_pc", pc_a, 32'h100);
      chk("jalr_trap_valid", {31'd0, tv_a}, 32'h1);
      chk("jalr_trap_epc", epc_a, 32'h40);
      chk("jalr_trap_tval", tval_a, 32'h1002);
      chk("jalr_ialign2_pc", pc_b, 32'h1002);
      idle(); step();
      chk("trap_pulse_ends", {31'd0, tv_a}, 32'h0);
      chk("epc_held", epc_a, 32'h40);

      cnt_before = cnt_a;
      set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      stall = 1'b1;
      repeat (3) step();
      chk("stall_pc", pc_a, 32'h104);
      chk("stall_count", {16'd0, cnt_a}, {16'd0, cnt_before});
      stall = 1'b0; step();
      chk("stall_release_pc", pc_a, 32'h114);
      chk("stall_release_count", {16'd0, cnt_a}, {16'd0, cnt_before + 16'd1});

      set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC - 32'h114, 32'h0); step();
      chk("pc_top", pc_a, 32'hFFFF_FFFC);
      idle(); step();
      chk("pc_wrap", pc_a, 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         stall     = ($urandom_range(0, 3) == 0);
         branch    = $urandom_range(0, 1);
         branch_op = 3'($urandom_range(0, 7));
         zero_flag = $urandom_range(0, 1);
         lt_flag   = $urandom_range(0, 1);
         ltu_flag  = $urandom_range(0, 1);
         jal       = ($urandom_range(0, 7) == 0);
         jalr      = ($urandom_range(0, 7) == 0);
         imm       = 32'($urandom_range(0, 1023)) - 32'd512;
         if ($urandom_range(0, 2) != 0) imm = imm & ~32'd3;
         rs1_val   = $urandom;
         if ($urandom_range(0, 1) != 0) rs1_val = rs1_val & ~32'd3;
         step();
      end

      for (int i = 0; i < 70000 && m_cnt[0] != 16'hFFFF; i++) begin
         set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
         step();
      end
      chk("count_ffff", {16'd0, cnt_a}, 32'hFFFF);
      step();
      chk("count_wrap", {16'd0, cnt_a}, 32'h0);

      // asynchronous reset during a trap pulse
      set_in(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h2, 32'h0); step();
      chk("pre_reset_trap", {31'd0, tv_a}, 32'h1);
      idle();
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("async_reset_pc", pc_a, 32'h0);
      chk("async_reset_trap", {31'd0, tv_a}, 32'h0);
      check_regs();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) step();
      chk("post_reset_pc", pc_a, 32'hC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
